// File: rtl/bit_serializer_pkg.sv
// Shared types and constants for the bit-serial front end and its detector bench.
// No logic; latency n/a; backpressure n/a.
// clog2 sizes the bit counter at elaboration time.
package serializer_pkg;

    localparam int DEFAULT_WIDTH = 8;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    function automatic int clog2(input int n);
        int r;
        r = 0;
        for (int i = 0; i < 32; i++) begin
            if ((1 << i) < n) r = i + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/bit_serializer_if.sv
// Word-in / bit-out bundle between a word producer and the serializer.
// No logic; latency n/a; backpressure via in_valid/in_ready.
// master = producer/observer side, slave = serializer side.
interface bit_serializer_if
    import serializer_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
);
    logic [WIDTH-1:0] in_data;
    logic             in_valid;
    logic             in_ready;
    logic             bit_en;
    logic             ser_out;
    logic             ser_valid;
    logic             frame_start;

    modport master (
        output in_data, in_valid, bit_en,
        input  in_ready, ser_out, ser_valid, frame_start
    );

    modport slave (
        input  in_data, in_valid, bit_en,
        output in_ready, ser_out, ser_valid, frame_start
    );
endinterface

// File: rtl/bit_serializer.sv
// Parallel-to-serial shifter with a one-word holding register, one bit per bit_en.
// Latency: word accepted at edge N shows its first bit after edge N+1.
// Backpressure: in_ready drops while the holding register is occupied.
module bit_serializer
    import serializer_pkg::*;
#(
    parameter int WIDTH     = DEFAULT_WIDTH,
    parameter bit MSB_FIRST = 1'b1,
    parameter bit IDLE_BIT  = 1'b0
) (
    input logic             clk,
    input logic             rst,
    bit_serializer_if.slave bus
);

    localparam int            CW   = clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    state_t           state;
    state_t           state_nxt;
    logic [WIDTH-1:0] hold;
    logic             hold_full;
    logic [WIDTH-1:0] shreg;
    logic [WIDTH-1:0] shreg_adv;
    logic [CW-1:0]    cnt;
    logic             out_bit;

    logic             ready;
    logic             accept;
    logic             last;
    logic             xfer;
    logic             adv;

    // Ready looks only at registers and reset, so it never waits on in_valid.
    assign ready  = rst & ~hold_full;
    assign accept = bus.in_valid & ready;

    generate
        if (MSB_FIRST) begin : g_msb_first
            assign out_bit   = shreg[WIDTH-1];
            assign shreg_adv = {shreg[WIDTH-2:0], 1'b0};
        end else begin : g_lsb_first
            assign out_bit   = shreg[0];
            assign shreg_adv = {1'b0, shreg[WIDTH-1:1]};
        end
    endgenerate

    always_comb begin
        last      = (cnt == LAST);
        xfer      = 1'b0;
        adv       = 1'b0;
        state_nxt = state;
        case (state)
            IDLE: begin
                // A waiting word launches immediately, bit_en or not.
                if (hold_full) begin
                    xfer      = 1'b1;
                    state_nxt = SHIFT;
                end
            end
            SHIFT: begin
                if (bus.bit_en) begin
                    if (!last) begin
                        adv = 1'b1;
                    end else if (hold_full) begin
                        xfer = 1'b1;
                    end else begin
                        state_nxt = IDLE;
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            hold      <= '0;
            hold_full <= 1'b0;
            shreg     <= '0;
            cnt       <= '0;
        end else begin
            // Accept wins over transfer so a same-edge refill keeps hold_full set.
            if (accept) begin
                hold      <= bus.in_data;
                hold_full <= 1'b1;
            end else if (xfer) begin
                hold_full <= 1'b0;
            end

            if (xfer) begin
                shreg <= hold;
                cnt   <= '0;
            end else if (adv) begin
                shreg <= shreg_adv;
                cnt   <= cnt + 1'b1;
            end
        end
    end

    assign bus.in_ready    = ready;
    assign bus.ser_valid   = (state == SHIFT);
    assign bus.frame_start = (state == SHIFT) && (cnt == '0);
    assign bus.ser_out     = (state == SHIFT) ? out_bit : IDLE_BIT;

endmodule

// File: tb/tb_bit_serializer.sv
// Bench: MSB-first/idle-0 and LSB-first/idle-1 serializers driven in lockstep,
// each cycle compared against a word-queue reference model.
module tb_bit_serializer;
    import serializer_pkg::*;

    localparam int W = 8;

    logic clk;
    logic rst;

    bit_serializer_if #(.WIDTH(W)) bus_m ();
    bit_serializer_if #(.WIDTH(W)) bus_l ();

    bit_serializer #(.WIDTH(W), .MSB_FIRST(1'b1), .IDLE_BIT(1'b0)) dut_msb (
        .clk (clk),
        .rst (rst),
        .bus (bus_m)
    );

    bit_serializer #(.WIDTH(W), .MSB_FIRST(1'b0), .IDLE_BIT(1'b1)) dut_lsb (
        .clk (clk),
        .rst (rst),
        .bus (bus_l)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int vectors     = 0;
    int miscompares = 0;

    // Reference: the word on the wire, how many of its bits remain, and the waiting queue.
    int             left;
    logic [W-1:0]   cur;
    logic [W-1:0]   pend_q[$];
    logic [15:0]    cap_m;
    logic [15:0]    cap_l;
    int             ncap;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        left = 0;
        cur  = '0;
        pend_q.delete();
    endtask

    task automatic drive(input logic v, input logic [W-1:0] d, input logic be);
        bus_m.in_valid = v;
        bus_m.in_data  = d;
        bus_m.bit_en   = be;
        bus_l.in_valid = v;
        bus_l.in_data  = d;
        bus_l.bit_en   = be;
    endtask

    // Called just after a falling edge: drive, check this cycle, advance model at the rising edge.
    task automatic cycle(input logic v, input logic [W-1:0] d, input logic be);
        int   sent;
        logic exp_m;
        logic exp_l;
        logic exp_rdy;
        logic acc;
        drive(v, d, be);
        if (!rst) model_reset();
        #1;
        sent  = W - left;
        exp_m = 1'b0;
        exp_l = 1'b1;
        if (left > 0) begin
            exp_m = cur[W-1-sent];
            exp_l = cur[sent];
        end
        exp_rdy = rst && (pend_q.size() == 0);
        check("msb_ser_out",     bus_m.ser_out,     exp_m);
        check("msb_ser_valid",   bus_m.ser_valid,   left > 0);
        check("msb_frame_start", bus_m.frame_start, left == W);
        check("msb_in_ready",    bus_m.in_ready,    exp_rdy);
        check("lsb_ser_out",     bus_l.ser_out,     exp_l);
        check("lsb_ser_valid",   bus_l.ser_valid,   left > 0);
        check("lsb_frame_start", bus_l.frame_start, left == W);
        check("lsb_in_ready",    bus_l.in_ready,    exp_rdy);
        if (bus_m.ser_valid) begin
            cap_m = {cap_m[14:0], bus_m.ser_out};
            ncap++;
        end
        if (bus_l.ser_valid) cap_l = {cap_l[14:0], bus_l.ser_out};
        acc = v && exp_rdy;
        @(posedge clk);
        if (!rst) begin
            model_reset();
        end else begin
            if (left > 0) begin
                if (be) begin
                    left--;
                    if (left == 0 && pend_q.size() > 0) begin
                        cur  = pend_q.pop_front();
                        left = W;
                    end
                end
            end else if (pend_q.size() > 0) begin
                cur  = pend_q.pop_front();
                left = W;
            end
            if (acc) pend_q.push_back(d);
        end
        @(negedge clk);
    endtask

    // Present each word with in_valid held high until the model says it was taken.
    task automatic send2(input logic [W-1:0] w0, input logic [W-1:0] w1);
        int idx;
        logic taken;
        idx = 0;
        for (int t = 0; t < 40 && idx < 2; t++) begin
            taken = rst && (pend_q.size() == 0);
            cycle(1'b1, (idx == 0) ? w0 : w1, 1'b1);
            if (taken) idx++;
        end
        check("send2_accepted", idx, 2);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1);
    end

    initial begin
        rst   = 1'b0;
        cap_m = '0;
        cap_l = '0;
        ncap  = 0;
        model_reset();
        drive(1'b0, '0, 1'b0);
        @(negedge clk);

        // Reset held, then first cycle after release must show ready.
        cycle(1'b1, 8'hB2, 1'b1);
        cycle(1'b1, 8'hB2, 1'b1);
        rst = 1'b1;
        cycle(1'b0, '0, 1'b1);

        // Single word at full rate.
        cycle(1'b1, 8'hB2, 1'b1);
        for (int t = 0; t < 12; t++) cycle(1'b0, '0, 1'b1);

        // Back-to-back words, captured directly from both outputs.
        cap_m = '0;
        cap_l = '0;
        ncap  = 0;
        send2(8'hB2, 8'h5A);
        for (int t = 0; t < 20; t++) cycle(1'b0, '0, 1'b1);
        check("b2b_bit_count",  ncap,  16);
        check("b2b_msb_stream", cap_m, 16'hB25A);
        check("b2b_lsb_stream", cap_l, 16'h4D5A);

        // Half bit rate.
        cycle(1'b1, 8'hB2, 1'b0);
        for (int t = 0; t < 40; t++) cycle(1'b0, '0, t[0]);

        // Reset after three bits with a second word waiting.
        send2(8'hB2, 8'h5A);
        for (int t = 0; t < 20 && left != W - 3; t++) cycle(1'b0, '0, 1'b1);
        check("mid_word_bits_left", left, W - 3);
        check("mid_word_pending",   pend_q.size(), 1);
        rst = 1'b0;
        cycle(1'b0, '0, 1'b1);
        cycle(1'b0, '0, 1'b1);
        rst = 1'b1;
        for (int t = 0; t < 12; t++) cycle(1'b0, '0, 1'b1);

        // Random traffic with random and full-rate bit strobes.
        for (int t = 0; t < 600; t++) begin
            cycle($urandom_range(0, 2) != 0, W'($urandom),
                  (t >= 300) ? 1'b1 : 1'($urandom_range(0, 1)));
        end
        for (int t = 0; t < 40; t++) cycle(1'b0, '0, 1'b1);
        check("drained_idle", left, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
